// File: rtl/write_back_multi_pkg.sv
// Shared micro-op types for the multi-lane write-back stage.
// Covers register, value, flags and exception codes plus the stage FSM states.
package write_back_multi_pkg;
  typedef logic [4:0]  reg_t;
  typedef logic [31:0] val_t;
  typedef logic [3:0]  flags_t;
  typedef logic [3:0]  ex_t;

  localparam ex_t EX_NONE = '0;

  typedef enum logic [0:0] {
    WB_RUN  = 1'b0,
    WB_TRAP = 1'b1
  } wb_state_t;
endpackage

// File: rtl/wb_bypass_history.sv
// Shift register of retired results for operand forwarding.
// Entry 0 is the newest; clear_i drops every entry to invalid.
module wb_bypass_history
  import write_back_multi_pkg::*;
#(
  parameter int LANES        = 2,
  parameter int BYPASS_DEPTH = 2
) (
  input  logic                                  clk,
  input  logic                                  clear_i,
  input  logic [LANES-1:0]                      valid_i,
  input  reg_t [LANES-1:0]                      r_i,
  input  val_t [LANES-1:0]                      val_i,
  output logic [BYPASS_DEPTH-1:0][LANES-1:0]    valid_o,
  output reg_t [BYPASS_DEPTH-1:0][LANES-1:0]    r_o,
  output val_t [BYPASS_DEPTH-1:0][LANES-1:0]    val_o
);

  logic [BYPASS_DEPTH-1:0][LANES-1:0] valid_q;
  reg_t [BYPASS_DEPTH-1:0][LANES-1:0] r_q;
  val_t [BYPASS_DEPTH-1:0][LANES-1:0] val_q;

  always_ff @(posedge clk) begin
    if (clear_i) begin
      valid_q <= '0;
      r_q     <= '0;
      val_q   <= '0;
    end else begin
      valid_q[0] <= valid_i;
      r_q[0]     <= r_i;
      val_q[0]   <= val_i;
      for (int d = 1; d < BYPASS_DEPTH; d++) begin
        valid_q[d] <= valid_q[d-1];
        r_q[d]     <= r_q[d-1];
        val_q[d]   <= val_q[d-1];
      end
    end
  end

  assign valid_o = valid_q;
  assign r_o     = r_q;
  assign val_o   = val_q;

endmodule

// File: rtl/write_back_multi.sv
// Multi-lane write-back: in-order retire, register-file writes, flags,
// forwarding history and precise capture of the oldest exception.
module write_back_multi
  import write_back_multi_pkg::*;
#(
  parameter int LANES        = 2,
  parameter int BYPASS_DEPTH = 2
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [LANES-1:0]                             in_valid,
  input  reg_t [LANES-1:0]                             in_rd,
  input  val_t [LANES-1:0]                             in_rd_val,
  input  logic [LANES-1:0]                             in_flags_valid,
  input  flags_t [LANES-1:0]                           in_flags,
  input  ex_t [LANES-1:0]                              in_ex,
  output logic                                         stall,
  output logic [LANES-1:0]                             wr_en,
  output reg_t [LANES-1:0]                             wr_addr,
  output val_t [LANES-1:0]                             wr_val,
  output logic [BYPASS_DEPTH-1:0][LANES-1:0]           byp_valid,
  output reg_t [BYPASS_DEPTH-1:0][LANES-1:0]           byp_r,
  output val_t [BYPASS_DEPTH-1:0][LANES-1:0]           byp_val,
  output flags_t                                       byp_flags,
  output logic                                         byp_flags_valid,
  output logic                                         trap_valid,
  output ex_t                                          trap_ex,
  output logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] trap_lane,
  input  logic                                         trap_ack,
  output logic                                         flush
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  wb_state_t       state_q, state_d;
  flags_t          flags_q, flags_d;
  ex_t             trap_ex_q, trap_ex_d;
  logic [LW-1:0]   trap_lane_q, trap_lane_d;
  logic            flush_q, flush_d;

  logic            run;
  logic            ex_found;
  logic [LW-1:0]   ex_lane;
  ex_t             ex_code;
  logic [LANES-1:0] commit;
  logic [LANES-1:0] wr_en_c;
  logic [LANES-1:0] hist_valid;
  reg_t [LANES-1:0] hist_r;
  val_t [LANES-1:0] hist_val;

  assign run = (state_q == WB_RUN);

  // Lanes at or after the oldest exception are masked out of commit.
  always_comb begin
    ex_found = 1'b0;
    ex_lane  = '0;
    ex_code  = EX_NONE;
    commit   = '0;
    for (int i = 0; i < LANES; i++) begin
      if (run && in_valid[i] && !ex_found) begin
        if (in_ex[i] != EX_NONE) begin
          ex_found = 1'b1;
          ex_lane  = LW'(i);
          ex_code  = in_ex[i];
        end else begin
          commit[i] = 1'b1;
        end
      end
    end
  end

  // Younger lane wins a same-rd conflict; history still keeps both.
  always_comb begin
    wr_en_c = '0;
    flags_d = flags_q;
    for (int i = 0; i < LANES; i++) begin
      wr_en_c[i] = commit[i] && (in_rd[i] != '0);
      if (commit[i] && in_flags_valid[i]) flags_d = in_flags[i];
    end
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (commit[j] && (in_rd[j] == in_rd[i])) wr_en_c[i] = 1'b0;
      end
    end
  end

  always_comb begin
    hist_valid = '0;
    hist_r     = '0;
    hist_val   = '0;
    if (run) begin
      hist_r   = in_rd;
      hist_val = in_rd_val;
      for (int i = 0; i < LANES; i++) begin
        hist_valid[i] = commit[i] && (in_rd[i] != '0);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_d     = 1'b0;
    trap_ex_d   = trap_ex_q;
    trap_lane_d = trap_lane_q;
    unique case (state_q)
      WB_RUN: begin
        if (ex_found) begin
          state_d     = WB_TRAP;
          flush_d     = 1'b1;
          trap_ex_d   = ex_code;
          trap_lane_d = ex_lane;
        end
      end
      WB_TRAP: begin
        if (trap_ack) state_d = WB_RUN;
      end
      default: state_d = WB_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WB_RUN;
      flags_q     <= '0;
      trap_ex_q   <= EX_NONE;
      trap_lane_q <= '0;
      flush_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      flags_q     <= flags_d;
      trap_ex_q   <= trap_ex_d;
      trap_lane_q <= trap_lane_d;
      flush_q     <= flush_d;
    end
  end

  wb_bypass_history #(
    .LANES        (LANES),
    .BYPASS_DEPTH (BYPASS_DEPTH)
  ) u_hist (
    .clk     (clk),
    .clear_i (rst),
    .valid_i (hist_valid),
    .r_i     (hist_r),
    .val_i   (hist_val),
    .valid_o (byp_valid),
    .r_o     (byp_r),
    .val_o   (byp_val)
  );

  assign stall           = (state_q == WB_TRAP);
  assign trap_valid      = (state_q == WB_TRAP);
  assign wr_en           = wr_en_c;
  assign wr_addr         = in_rd;
  assign wr_val          = in_rd_val;
  assign byp_flags       = flags_q;
  assign byp_flags_valid = 1'b1;
  assign trap_ex         = trap_ex_q;
  assign trap_lane       = trap_lane_q;
  assign flush           = flush_q;

endmodule

// File: doc/write_back_multi.md
# write_back_multi

Parametrised multi-lane write-back stage: retires up to LANES micro-ops per cycle in program order and drives one register-file write port per lane. It also keeps a BYPASS_DEPTH-deep history of retired results for operand forwarding, maintains the architectural flags register, and captures the first exception precisely before handing it to the trap logic. It sits at the tail of the pipeline, after the memory stage, and replaces the single-lane write-back stage in wide configurations.

## Interface
- LANES, 2, retire lanes per cycle; lane 0 is oldest in program order.
- BYPASS_DEPTH, 2, cycles of retired-result history exposed for forwarding.
- Data types come from Uop: reg_t (5 b), val_t (32 b), flags_t (4 b), ex_t (EX_NONE = 0).
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  LANES  per-lane uop valid from the memory stage.
- in_rd  in  LANES x reg_t  destination register.
- in_rd_val  in  LANES x val_t  result value.
- in_flags_valid  in  LANES  lane updates flags.
- in_flags  in  LANES x flags_t  new flags.
- in_ex  in  LANES x ex_t  exception code; EX_NONE means none.
- stall  out  1  upstream stall.
- wr_en  out  LANES  register-file write enable.
- wr_addr  out  LANES x reg_t  write address.
- wr_val  out  LANES x val_t  write data.
- byp_valid  out  BYPASS_DEPTH x LANES  history entry valid; entry 0 is newest.
- byp_r  out  BYPASS_DEPTH x LANES x reg_t  history destination.
- byp_val  out  BYPASS_DEPTH x LANES x val_t  history value.
- byp_flags  out  flags_t  architectural flags register.
- byp_flags_valid  out  1  constant 1.
- trap_valid  out  1  exception pending.
- trap_ex  out  ex_t  captured exception code.
- trap_lane  out  $clog2(LANES) (min 1)  lane of the captured exception.
- trap_ack  in  1  trap logic accepts the exception.
- flush  out  1  one-cycle pulse that kills younger in-flight uops.

## Operation
- The block has two states, RUN and TRAP. Reset enters RUN.
- Commit is evaluated in RUN only. Let k be the lowest lane with in_valid and in_ex != EX_NONE; if there is none, k = LANES.
  - Lane i commits iff in_valid[i] and i < k.
  - The excepting lane and all younger lanes never write registers, flags or history.
- wr_en[i] = commit[i] and in_rd[i] != 0. Writes to x0 are dropped everywhere, including history.
- Same-rd conflict: if committing lanes i < j share rd, wr_en[i] is forced to 0 and the younger lane wins.
  - History still records both lanes; forwarding consumers pick the highest lane.
- Flags: the youngest committing lane with in_flags_valid loads its in_flags into the flags register. If no such lane exists, the flags hold.
- History is a shift register. Each RUN cycle, entry 0 loads {commit[i] and rd != 0, rd, val} for every lane, and entry d loads entry d-1.
- In TRAP, history shifts with all-invalid entries, so it drains to invalid after BYPASS_DEPTH cycles.
- State transitions:
  - RUN -> TRAP when k < LANES. At the same edge the block latches trap_ex = in_ex[k] and trap_lane = k.
  - TRAP -> RUN at the edge where trap_ack = 1.
- Outputs by state:
  - stall = 0 in RUN and 1 in TRAP.
  - In TRAP, in_valid is ignored and wr_en = 0.
  - trap_valid = 1 exactly while in TRAP.
- flush is registered and equals 1 for exactly the first cycle of TRAP.

## Timing
- Register-file writes are combinational from the inputs, so they take effect in the same cycle as in_valid. The register file captures them at the next edge.
- Forwarding has one cycle of latency: history entry d reflects the uops retired d+1 cycles ago.
- Flags update at the edge after commit.
- Trap path: trap_valid and flush rise one cycle after the excepting uop is presented.
  - trap_ack is sampled from the first TRAP cycle on.
  - The minimum TRAP duration is 1 cycle, when trap_ack = 1 in the first TRAP cycle.
- Reset values: state RUN, all history entries invalid (r and val = 0), flags = 0, trap_valid = 0, trap_ex = EX_NONE, trap_lane = 0, flush = 0, stall = 0.
- Reset mid-TRAP returns to RUN in the next cycle and drops the pending exception.
- A trap_ack received in RUN is ignored.

## Structure
- Add wb_state_t {WB_RUN, WB_TRAP} and the EX_NONE constant to the Uop package.
- Natural sub-module: wb_bypass_history. It holds the shift register, is parametrised by LANES and BYPASS_DEPTH, and takes a shift-in vector plus a clear input.
- Commit masking, conflict resolution and the flags selection loop live in the top module as a combinational block.

## Test plan
- LANES=2 RUN: lane0 rd=3 val=0x11, lane1 rd=4 val=0x22 -> wr_en=11 this cycle; next cycle byp entry 0 shows both valid; two cycles later entry 1 shows them.
- Same rd: both lanes rd=5 (0xA, 0xB) -> wr_en=01, wr_val[1]=0xB; history holds both entries.
- rd=0 in lane0 with val=0xFF -> wr_en[0]=0 and byp_valid[0][0]=0 next cycle.
- Flags: lane0 flagsValid with flags=0x1 and lane1 flagsValid with flags=0x8 -> byp_flags=0x8 next cycle; a cycle with no flagsValid holds 0x8.
- Exception in lane 0, lane1 valid -> no writes; next cycle trap_valid=1, trap_lane=0, flush=1 for one cycle, stall=1; trap_ack held low 3 cycles keeps TRAP; ack -> RUN next cycle with stall=0.
- Exception in lane 1 with lane0 rd=7 -> lane0 commits; then assert rst during TRAP -> next cycle trap_valid=0, flags=0, all history invalid.
